// File: rtl/sm_trace_buf_pkg.sv
// Shared types and widths for the schoolMIPS instruction-trace buffer.
// Optional feature macro: SM_TRACE_CYCLE_EN (adds a 16-bit inter-capture cycle delta per entry).
package sm_trace_buf_pkg;

  // Capture/readout sequencer states.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArmed = 3'd1,
    StPost  = 3'd2,
    StDone  = 3'd3,
    StDrain = 3'd4
  } tr_state_e;

  localparam int unsigned PcW    = 32;
  localparam int unsigned InstrW = 32;
  localparam int unsigned DeltaW = 16;

`ifdef SM_TRACE_CYCLE_EN
  localparam int unsigned EntryW = DeltaW + PcW + InstrW;
`else
  localparam int unsigned EntryW = PcW + InstrW;
`endif

  // Saturating increment for the cycle-delta counter.
  function automatic logic [DeltaW-1:0] sat_inc(input logic [DeltaW-1:0] v);
    return (v == {DeltaW{1'b1}}) ? v : v + DeltaW'(1);
  endfunction

endpackage

// File: rtl/sm_trace_buf_ram.sv
// Simple dual-port trace RAM: one write port, one registered read port with read enable.
// The read register only updates on i_re, so the readout entry holds while the consumer stalls.
// Contents are deliberately not reset.
module sm_trace_buf_ram #(
  parameter int unsigned AddrW = 4,
  parameter int unsigned DataW = 64
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AddrW-1:0] i_waddr,
  input  logic [DataW-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AddrW-1:0] i_raddr,
  output logic [DataW-1:0] o_rdata
);

  logic [DataW-1:0] r_mem [2**AddrW];
  logic [DataW-1:0] r_rdata;

  // Write port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Synchronous read port, held when not enabled.
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sm_trace_buf.sv
// Instruction-trace capture buffer for schoolMIPS.
// Samples (pc, instr) per executed instruction into a circular buffer, freezes a window that
// ends POST_TRIG entries after a PC-match trigger, then streams it oldest-first on a
// valid/ready port. Optional feature macro: SM_TRACE_CYCLE_EN (adds rd_delta output).
module sm_trace_buf
  import sm_trace_buf_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned POST_TRIG  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arm,
  input  logic [31:0] trig_pc,
  input  logic        cap_en,
  input  logic [31:0] cap_pc,
  input  logic [31:0] cap_instr,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_pc,
  output logic [31:0] rd_instr,
  output logic        rd_last,
`ifdef SM_TRACE_CYCLE_EN
  output logic [15:0] rd_delta,
`endif
  output logic        busy
);

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  localparam ptr_t PtrOne   = ptr_t'(1);
  localparam cnt_t CntOne   = cnt_t'(1);
  localparam cnt_t CntTwo   = cnt_t'(2);
  localparam ptr_t PostInit = ptr_t'(POST_TRIG);

  tr_state_e r_state;
  ptr_t      r_wr_ptr;
  ptr_t      r_rd_ptr;
  ptr_t      r_post_cnt;
  cnt_t      r_count;
  cnt_t      r_remain;
  logic      r_rd_valid;
  logic      r_rd_last;
  logic      r_busy;

  logic              w_cap;
  logic              w_hs;
  ptr_t              w_start;
  logic              w_rd_en;
  ptr_t              w_rd_addr;
  logic [EntryW-1:0] w_wdata;
  logic [EntryW-1:0] w_rdata;

  // Strobes are only recorded while a capture run is collecting entries.
  assign w_cap   = cap_en && ((r_state == StArmed) || (r_state == StPost));
  assign w_hs    = r_rd_valid && rd_ready;
  // Oldest surviving entry; with a full buffer this equals wr_ptr.
  assign w_start = r_wr_ptr - r_count[DEPTH_LOG2-1:0];

  // Read-address lookahead: fetch the first entry in DONE and the next one on each handshake,
  // so the RAM output is ready in the cycle rd_valid is seen.
  always_comb begin
    w_rd_en   = 1'b0;
    w_rd_addr = r_rd_ptr + PtrOne;
    if (r_state == StDone) begin
      w_rd_en   = 1'b1;
      w_rd_addr = w_start;
    end else if (w_hs && !r_rd_last) begin
      w_rd_en   = 1'b1;
    end
  end

`ifdef SM_TRACE_CYCLE_EN
  logic [DeltaW-1:0] r_cyc;
  logic              r_first;
  logic [DeltaW-1:0] w_delta;

  assign w_delta = r_first ? '0 : r_cyc;
  assign w_wdata = {w_delta, cap_pc, cap_instr};

  // Cycles since the previous captured strobe, restarted by each capture, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cyc   <= '0;
      r_first <= 1'b1;
    end else if ((r_state == StIdle) && arm) begin
      r_cyc   <= '0;
      r_first <= 1'b1;
    end else if (w_cap) begin
      r_cyc   <= DeltaW'(1);
      r_first <= 1'b0;
    end else begin
      r_cyc   <= sat_inc(r_cyc);
    end
  end
`else
  assign w_wdata = {cap_pc, cap_instr};
`endif

  sm_trace_buf_ram #(
    .AddrW (DEPTH_LOG2),
    .DataW (EntryW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_cap),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_re    (w_rd_en),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rdata)
  );

  // Capture/readout sequencer with registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_post_cnt <= '0;
      r_count    <= '0;
      r_remain   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (arm) begin
            r_state  <= StArmed;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_busy   <= 1'b1;
          end
        end
        StArmed: begin
          if (cap_en) begin
            r_wr_ptr <= r_wr_ptr + PtrOne;
            if (!r_count[DEPTH_LOG2]) begin
              r_count <= r_count + CntOne;
            end
            if (cap_pc == trig_pc) begin
              r_post_cnt <= PostInit;
              r_state    <= (POST_TRIG == 0) ? StDone : StPost;
            end
          end
        end
        StPost: begin
          // Trigger PC is not re-checked here.
          if (cap_en) begin
            r_wr_ptr   <= r_wr_ptr + PtrOne;
            r_post_cnt <= r_post_cnt - PtrOne;
            if (!r_count[DEPTH_LOG2]) begin
              r_count <= r_count + CntOne;
            end
            if (r_post_cnt == PtrOne) begin
              r_state <= StDone;
            end
          end
        end
        StDone: begin
          r_rd_ptr   <= w_start;
          r_remain   <= r_count;
          r_rd_valid <= 1'b1;
          r_rd_last  <= (r_count == CntOne);
          r_state    <= StDrain;
        end
        StDrain: begin
          if (w_hs) begin
            if (r_rd_last) begin
              r_state    <= StIdle;
              r_rd_valid <= 1'b0;
              r_rd_last  <= 1'b0;
              r_busy     <= 1'b0;
            end else begin
              r_rd_ptr  <= r_rd_ptr + PtrOne;
              r_remain  <= r_remain - CntOne;
              r_rd_last <= (r_remain == CntTwo);
            end
          end
        end
        default: begin
          r_state    <= StIdle;
          r_rd_valid <= 1'b0;
          r_rd_last  <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  // Data outputs are gated by valid so stale RAM contents never appear on the port.
  always_comb begin
    rd_valid = r_rd_valid;
    rd_last  = r_rd_last;
    busy     = r_busy;
    rd_pc    = r_rd_valid ? w_rdata[PcW+InstrW-1:InstrW] : '0;
    rd_instr = r_rd_valid ? w_rdata[InstrW-1:0] : '0;
`ifdef SM_TRACE_CYCLE_EN
    rd_delta = r_rd_valid ? w_rdata[EntryW-1:PcW+InstrW] : '0;
`endif
  end

endmodule

// File: tb/tb_sm_trace_buf.sv
// Self-checking bench for sm_trace_buf: two instances (POST_TRIG = 2 and 0, depth 16).
// Honours SM_TRACE_CYCLE_EN to also check rd_delta.
module tb_sm_trace_buf;

  localparam int Depth = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, arm2, arm0, cap_en, rd_ready;
  logic [31:0] trig_pc, cap_pc, cap_instr;
  logic        v2, l2, b2, v0, l0, b0;
  logic [31:0] p2, i2, p0, i0;
`ifdef SM_TRACE_CYCLE_EN
  logic [15:0] d2, d0, w_delta;
`endif

  bit          sel;  // 0: POST_TRIG=2 instance, 1: POST_TRIG=0 instance
  logic        w_valid, w_last, w_busy;
  logic [31:0] w_pc, w_instr;

  assign w_valid = sel ? v0 : v2;
  assign w_last  = sel ? l0 : l2;
  assign w_busy  = sel ? b0 : b2;
  assign w_pc    = sel ? p0 : p2;
  assign w_instr = sel ? i0 : i2;
`ifdef SM_TRACE_CYCLE_EN
  assign w_delta = sel ? d0 : d2;
`endif

  sm_trace_buf #(.DEPTH_LOG2(4), .POST_TRIG(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .arm(arm2), .trig_pc(trig_pc), .cap_en(cap_en),
    .cap_pc(cap_pc), .cap_instr(cap_instr), .rd_valid(v2), .rd_ready(rd_ready),
    .rd_pc(p2), .rd_instr(i2), .rd_last(l2),
`ifdef SM_TRACE_CYCLE_EN
    .rd_delta(d2),
`endif
    .busy(b2)
  );

  sm_trace_buf #(.DEPTH_LOG2(4), .POST_TRIG(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .arm(arm0), .trig_pc(trig_pc), .cap_en(cap_en),
    .cap_pc(cap_pc), .cap_instr(cap_instr), .rd_valid(v0), .rd_ready(rd_ready),
    .rd_pc(p0), .rd_instr(i0), .rd_last(l0),
`ifdef SM_TRACE_CYCLE_EN
    .rd_delta(d0),
`endif
    .busy(b0)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          gap;    // idle cycles after this strobe
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [15:0] delta;
  } ent_t;

  typedef struct {
    bit          arm;
    bit          cap;
    logic [31:0] pc;
    bit          rdy;
    bit          ev;
    logic [31:0] epc;
    bit          elast;
    bit          ebusy;
  } vec_t;

  stim_t stim_q[$];
  ent_t  exp_q[$];
  vec_t  tbl[14];
  int    n_chk = 0;
  int    n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit a, bit c, logic [31:0] pc, bit r, bit ev, logic [31:0] epc,
                              bit el, bit eb);
    vec_t v;
    v.arm = a; v.cap = c; v.pc = pc; v.rdy = r;
    v.ev = ev; v.epc = epc; v.elast = el; v.ebusy = eb;
    return v;
  endfunction

  // Reference: the window is the last min(n, Depth) strobes after arm, ending `post`
  // strobes after the first strobe whose pc equals the trigger.
  task automatic build_exp(input logic [31:0] trig, input int post);
    int   t = -1;
    int   e, s, d;
    ent_t en;
    exp_q.delete();
    for (int i = 0; i < stim_q.size(); i++) begin
      if (t < 0 && stim_q[i].pc == trig) t = i;
    end
    if (t < 0) return;
    e = t + post;
    if (e >= stim_q.size()) e = stim_q.size() - 1;
    s = e - Depth + 1;
    if (s < 0) s = 0;
    for (int i = s; i <= e; i++) begin
      en.pc    = stim_q[i].pc;
      en.instr = stim_q[i].instr;
      d        = (i == 0) ? 0 : stim_q[i-1].gap + 1;
      en.delta = (d > 65535) ? 16'hFFFF : 16'(d);
      exp_q.push_back(en);
    end
  endtask

  task automatic add_stim(input logic [31:0] pc, input logic [31:0] instr, input int gap);
    stim_t s;
    s.pc = pc; s.instr = instr; s.gap = gap;
    stim_q.push_back(s);
  endtask

  task automatic run_capture(input bit which0, input logic [31:0] trig);
    sel     = which0;
    trig_pc = trig;
    if (which0) arm0 = 1'b1;
    else        arm2 = 1'b1;
    @(negedge clk);
    arm0 = 1'b0;
    arm2 = 1'b0;
    foreach (stim_q[i]) begin
      cap_en    = 1'b1;
      cap_pc    = stim_q[i].pc;
      cap_instr = stim_q[i].instr;
      @(negedge clk);
      cap_en = 1'b0;
      repeat (stim_q[i].gap) @(negedge clk);
    end
  endtask

  task automatic wait_valid(input string tag);
    int b = 0;
    while (!w_valid && b < 50) begin
      @(negedge clk);
      b++;
    end
    chk(tag, 32'(w_valid), 32'd1);
  endtask

  // Drain the readout, comparing every presented cycle against exp_q.
  task automatic drain(input int stall_at, input bit rnd, input string tag);
    int k = 0, budget = 0, stalls = 0, first = -1, cyc = 0;
    bit rdy, hs;
    while (k < exp_q.size() && budget < 4000) begin
      if (w_valid) begin
        if (first < 0) first = cyc;
        chk({tag, "_pc"}, w_pc, exp_q[k].pc);
        chk({tag, "_instr"}, w_instr, exp_q[k].instr);
        chk({tag, "_last"}, 32'(w_last), 32'(k == exp_q.size() - 1));
`ifdef SM_TRACE_CYCLE_EN
        chk({tag, "_delta"}, 32'(w_delta), 32'(exp_q[k].delta));
`endif
      end else if (k > 0) begin
        chk({tag, "_valid_drop"}, 32'(w_valid), 32'd1);
      end
      rdy = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (k == stall_at && w_valid && stalls < 5) begin
        rdy = 1'b0;
        stalls++;
      end
      rd_ready = rdy;
      hs       = w_valid && rdy;
      @(negedge clk);
      if (hs) k++;
      cyc++;
      budget++;
    end
    rd_ready = 1'b0;
    chk({tag, "_count"}, 32'(k), 32'(exp_q.size()));
    chk({tag, "_end_valid"}, 32'(w_valid), 32'd0);
    chk({tag, "_end_busy"}, 32'(w_busy), 32'd0);
    if (!rnd && first >= 0) chk({tag, "_rate"}, 32'(cyc - first), 32'(exp_q.size() + stalls));
  endtask

  task automatic gen_random(input int post, output logic [31:0] trig);
    int n_pre, n;
    logic [31:0] pc;
    n_pre = int'($urandom_range(0, 25));
    n     = n_pre + 1 + post + int'($urandom_range(0, 5));
    trig  = 32'($urandom_range(0, 7));
    stim_q.delete();
    for (int i = 0; i < n; i++) begin
      if (i == n_pre)     pc = trig;
      else if (i < n_pre) pc = (trig + 32'd1 + 32'($urandom_range(0, 6))) % 32'd8;
      else                pc = 32'($urandom_range(0, 7));
      add_stim(pc, $urandom, int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] trig;

    rst_n = 1'b0; arm2 = 1'b0; arm0 = 1'b0; cap_en = 1'b0; rd_ready = 1'b0;
    trig_pc = 32'd3; cap_pc = '0; cap_instr = '0; sel = 1'b0;

    // Basic-window vectors for the POST_TRIG=2 instance, trigger pc 3, feed pc 0..5.
    tbl[0] = mk(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) tbl[1+i] = mk(1'b0, 1'b1, 32'(i), 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    tbl[7] = mk(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'd0, 1'b0, 1'b1);
    for (int i = 1; i < 6; i++) tbl[7+i] = mk(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'(i), i == 5, 1'b1);
    tbl[13] = mk(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);

    // Reset held for 4 clocks.
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_valid2", 32'(v2), 32'd0);
    chk("rst_busy2", 32'(b2), 32'd0);
    chk("rst_pc2", p2, 32'd0);
    chk("rst_last2", 32'(l2), 32'd0);
    chk("rst_valid0", 32'(v0), 32'd0);
    chk("rst_busy0", 32'(b0), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Strobes while idle (even matching the trigger) must be ignored.
    for (int i = 0; i < 4; i++) begin
      cap_en = 1'b1; cap_pc = 32'd3; cap_instr = 32'hDEAD_0000 + 32'(i);
      @(negedge clk);
    end
    cap_en = 1'b0;
    chk("idle_busy", 32'(b2), 32'd0);

    // Table-driven basic window.
    sel = 1'b0;
    for (int r = 0; r < 14; r++) begin
      arm2      = tbl[r].arm;
      cap_en    = tbl[r].cap;
      cap_pc    = tbl[r].pc;
      cap_instr = tbl[r].pc ^ 32'hA5A5_0000;
      rd_ready  = tbl[r].rdy;
      @(negedge clk);
      arm2   = 1'b0;
      cap_en = 1'b0;
      chk($sformatf("tbl%0d_valid", r), 32'(w_valid), 32'(tbl[r].ev));
      chk($sformatf("tbl%0d_busy", r), 32'(w_busy), 32'(tbl[r].ebusy));
      chk($sformatf("tbl%0d_last", r), 32'(w_last), 32'(tbl[r].elast));
      if (tbl[r].ev) begin
        chk($sformatf("tbl%0d_pc", r), w_pc, tbl[r].epc);
        chk($sformatf("tbl%0d_instr", r), w_instr, tbl[r].epc ^ 32'hA5A5_0000);
      end
    end
    rd_ready = 1'b0;

    // Wrap: trigger 30 of pcs 0..40 leaves pcs 17..32.
    stim_q.delete();
    for (int i = 0; i <= 40; i++) add_stim(32'(i), $urandom, 0);
    build_exp(32'd30, 2);
    run_capture(1'b0, 32'd30);
    drain(-1, 1'b0, "wrap");

    // Backpressure: 5 stalled cycles on the third entry.
    stim_q.delete();
    for (int i = 0; i < 6; i++) add_stim(32'(i), $urandom, 0);
    build_exp(32'd3, 2);
    run_capture(1'b0, 32'd3);
    drain(2, 1'b0, "bp");

    // POST_TRIG = 0, trigger on the very first strobe: single entry.
    stim_q.delete();
    add_stim(32'd7, $urandom, 0);
    add_stim(32'd8, $urandom, 0);
    add_stim(32'd9, $urandom, 0);
    build_exp(32'd7, 0);
    run_capture(1'b1, 32'd7);
    drain(-1, 1'b0, "p0");

    // arm during DRAIN is ignored.
    stim_q.delete();
    for (int i = 0; i < 6; i++) add_stim(32'(i + 50), $urandom, 1);
    build_exp(32'd52, 2);
    run_capture(1'b0, 32'd52);
    wait_valid("armdrain_wait");
    arm2 = 1'b1;
    @(negedge clk);
    arm2 = 1'b0;
    drain(-1, 1'b0, "armdrain");

    // Reset in the middle of DRAIN.
    stim_q.delete();
    for (int i = 0; i < 8; i++) add_stim(32'(i + 200), $urandom, 0);
    build_exp(32'd203, 2);
    run_capture(1'b0, 32'd203);
    wait_valid("rstdrain_wait");
    rd_ready = 1'b1;
    repeat (2) @(negedge clk);
    rd_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstdrain_valid", 32'(v2), 32'd0);
    chk("rstdrain_busy", 32'(b2), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstdrain_valid_after", 32'(v2), 32'd0);
    stim_q.delete();
    for (int i = 0; i < 3; i++) add_stim(32'(i + 100), $urandom, 0);
    build_exp(32'd100, 2);
    run_capture(1'b0, 32'd100);
    drain(-1, 1'b0, "postrst");

    // Randomized runs against the window model on both instances.
    for (int it = 0; it < 16; it++) begin
      gen_random((it % 2 == 1) ? 0 : 2, trig);
      build_exp(trig, (it % 2 == 1) ? 0 : 2);
      run_capture(it % 2 == 1, trig);
      drain(-1, 1'b1, $sformatf("rnd%0d", it));
    end

`ifdef SM_TRACE_CYCLE_EN
    // Strobes every 3rd cycle, then a 70000-cycle gap before the final post-trigger strobe.
    stim_q.delete();
    for (int i = 0; i < 5; i++) add_stim(32'(i), $urandom, (i == 4) ? 69999 : 2);
    add_stim(32'd5, $urandom, 0);
    build_exp(32'd3, 2);
    run_capture(1'b0, 32'd3);
    drain(-1, 1'b0, "delta");
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
